uart_alu_uart: RTL and testbench

Glue block between a UART receiver and a UART transmitter. It collects three received bytes (operand A, operand B, opcode), computes an 8-bit ALU result, and issues a one-cycle transmit request carrying the result. It sits between the UART RX `rx_done_tick`/`rx_data` outputs and the UART TX `tx_start`/`tx_data` inputs.

---
 rtl/uart_alu_uart_pkg.sv | 24 ++
 rtl/uart_alu_uart_if.sv | 28 ++
 rtl/uart_alu_uart_alu.sv | 46 ++++
 rtl/uart_alu_uart.sv | 100 ++++++++++
 tb/tb_uart_alu_uart.sv | 131 +++++++++++++
 5 files changed

// File: rtl/uart_alu_uart_pkg.sv
// Shared definitions for the UART-fed ALU glue block: default widths,
// MIPS-funct-style opcodes and the 2-bit FSM state encoding.
package uart_alu_uart_pkg;

  localparam int NB_DATA_DEF = 8;
  localparam int NB_OP_DEF   = 6;

  localparam logic [NB_OP_DEF-1:0] OP_ADD = 6'b100000;
  localparam logic [NB_OP_DEF-1:0] OP_SUB = 6'b100010;
  localparam logic [NB_OP_DEF-1:0] OP_AND = 6'b100100;
  localparam logic [NB_OP_DEF-1:0] OP_OR  = 6'b100101;
  localparam logic [NB_OP_DEF-1:0] OP_XOR = 6'b100110;
  localparam logic [NB_OP_DEF-1:0] OP_NOR = 6'b100111;
  localparam logic [NB_OP_DEF-1:0] OP_SRA = 6'b000011;
  localparam logic [NB_OP_DEF-1:0] OP_SRL = 6'b000010;

  typedef enum logic [1:0] {
    ST_WAIT_A  = 2'b00,
    ST_WAIT_B  = 2'b01,
    ST_WAIT_OP = 2'b10,
    ST_SEND    = 2'b11
  } state_e;

endpackage : uart_alu_uart_pkg

// File: rtl/uart_alu_uart_if.sv
// Byte-level link between the UART RX/TX pair (master side) and the ALU
// glue block (slave side).
interface uart_alu_uart_if
  import uart_alu_uart_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF
);

  logic               rx_done_tick;
  logic [NB_DATA-1:0] rx_data;
  logic               tx_start;
  logic [NB_DATA-1:0] tx_data;

  modport master (
    output rx_done_tick,
    output rx_data,
    input  tx_start,
    input  tx_data
  );

  modport slave (
    input  rx_done_tick,
    input  rx_data,
    output tx_start,
    output tx_data
  );

endinterface : uart_alu_uart_if

// File: rtl/uart_alu_uart_alu.sv
// Purely combinational 8-op ALU (a, b, op -> result); unknown opcodes give 0.
module alu
  import uart_alu_uart_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_OP   = NB_OP_DEF
) (
  input  logic [NB_DATA-1:0] i_a,
  input  logic [NB_DATA-1:0] i_b,
  input  logic [NB_OP-1:0]   i_op,
  output logic [NB_DATA-1:0] o_result
);

  logic               big_shift_s;
  logic [NB_DATA-1:0] sra_s;
  logic [NB_DATA-1:0] srl_s;

  // Shift amounts at or beyond the word width saturate to pure sign/zero fill.
  always_comb begin
    big_shift_s = (32'(i_b) >= 32'(NB_DATA));
    if (big_shift_s) begin
      sra_s = {NB_DATA{i_a[NB_DATA-1]}};
      srl_s = {NB_DATA{1'b0}};
    end else begin
      sra_s = NB_DATA'($signed(i_a) >>> i_b);
      srl_s = i_a >> i_b;
    end
  end

  // Opcode decode; add/sub wrap and drop carry.
  always_comb begin
    o_result = {NB_DATA{1'b0}};
    case (i_op)
      OP_ADD:  o_result = i_a + i_b;
      OP_SUB:  o_result = i_a - i_b;
      OP_AND:  o_result = i_a & i_b;
      OP_OR:   o_result = i_a | i_b;
      OP_XOR:  o_result = i_a ^ i_b;
      OP_NOR:  o_result = ~(i_a | i_b);
      OP_SRA:  o_result = sra_s;
      OP_SRL:  o_result = srl_s;
      default: o_result = {NB_DATA{1'b0}};
    endcase
  end

endmodule : alu

// File: rtl/uart_alu_uart.sv
// Collects operand A, operand B and opcode from UART RX, then issues a single
// registered transmit request carrying the ALU result.
module uart_alu_uart
  import uart_alu_uart_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_OP   = NB_OP_DEF
) (
  input  logic          i_clk,
  input  logic          i_rst,
  uart_alu_uart_if.slave bus
);

  state_e             state_q, state_d;
  logic [NB_DATA-1:0] reg_a_q, reg_a_d;
  logic [NB_DATA-1:0] reg_b_q, reg_b_d;
  logic [NB_OP-1:0]   reg_op_q, reg_op_d;
  logic               tx_start_q, tx_start_d;
  logic [NB_DATA-1:0] tx_data_q, tx_data_d;
  logic [NB_DATA-1:0] alu_result_s;

  // The opcode is fed from its next-value so the result can be registered on
  // the same edge that captures the opcode byte and enters SEND.
  alu #(
    .NB_DATA (NB_DATA),
    .NB_OP   (NB_OP)
  ) u_alu (
    .i_a      (reg_a_q),
    .i_b      (reg_b_q),
    .i_op     (reg_op_d),
    .o_result (alu_result_s)
  );

  // Next-state, operand capture and transmit request generation.
  always_comb begin
    state_d    = state_q;
    reg_a_d    = reg_a_q;
    reg_b_d    = reg_b_q;
    reg_op_d   = reg_op_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    case (state_q)
      ST_WAIT_A: begin
        if (bus.rx_done_tick) begin
          reg_a_d = bus.rx_data;
          state_d = ST_WAIT_B;
        end else begin
          state_d = ST_WAIT_A;
        end
      end
      ST_WAIT_B: begin
        if (bus.rx_done_tick) begin
          reg_b_d = bus.rx_data;
          state_d = ST_WAIT_OP;
        end else begin
          state_d = ST_WAIT_B;
        end
      end
      ST_WAIT_OP: begin
        if (bus.rx_done_tick) begin
          reg_op_d   = bus.rx_data[NB_OP-1:0];
          state_d    = ST_SEND;
          tx_start_d = 1'b1;
          tx_data_d  = alu_result_s;
        end else begin
          state_d = ST_WAIT_OP;
        end
      end
      ST_SEND: begin
        state_d = ST_WAIT_A;
      end
      default: begin
        state_d = ST_WAIT_A;
      end
    endcase
  end

  // State, operand and output registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= ST_WAIT_A;
      reg_a_q    <= {NB_DATA{1'b0}};
      reg_b_q    <= {NB_DATA{1'b0}};
      reg_op_q   <= {NB_OP{1'b0}};
      tx_start_q <= 1'b0;
      tx_data_q  <= {NB_DATA{1'b0}};
    end else begin
      state_q    <= state_d;
      reg_a_q    <= reg_a_d;
      reg_b_q    <= reg_b_d;
      reg_op_q   <= reg_op_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;

endmodule : uart_alu_uart

// File: tb/tb_uart_alu_uart.sv
// Directed self-checking bench: feeds byte triples and checks the single
// transmit pulse and its data against hand-computed results.
module tb_uart_alu_uart;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   pulse_cnt;
  int   dbl_cnt;
  logic prev_start;

  uart_alu_uart_if #(.NB_DATA(8)) bus ();

  uart_alu_uart #(
    .NB_DATA (8),
    .NB_OP   (6)
  ) dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count transmit pulses and any back-to-back high cycles.
  always @(posedge clk) begin
    prev_start <= bus.tx_start;
    if (bus.tx_start === 1'b1) begin
      pulse_cnt <= pulse_cnt + 1;
    end
    if (bus.tx_start === 1'b1 && prev_start === 1'b1) begin
      dbl_cnt <= dbl_cnt + 1;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    bus.rx_data      = b;
    bus.rx_done_tick = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_done_tick = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] op, input logic [7:0] exp, input int gap);
    int p0;
    p0 = pulse_cnt;
    send_byte(a, gap);
    send_byte(b, gap);
    send_byte(op, 0);
    check_val({tag, "_start"}, 32'(bus.tx_start), 32'd1);
    check_val({tag, "_data"}, 32'(bus.tx_data), 32'(exp));
    @(posedge clk);
    #1;
    check_val({tag, "_start_low"}, 32'(bus.tx_start), 32'd0);
    repeat (6) @(posedge clk);
    #1;
    check_val({tag, "_pulses"}, 32'(pulse_cnt - p0), 32'd1);
  endtask

  initial begin
    n_checks         = 0;
    n_fail           = 0;
    pulse_cnt        = 0;
    dbl_cnt          = 0;
    prev_start       = 1'b0;
    rst_n            = 1'b0;
    bus.rx_done_tick = 1'b0;
    bus.rx_data      = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    check_val("rst_start", 32'(bus.tx_start), 32'd0);
    check_val("rst_data", 32'(bus.tx_data), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);

    run_op("add", 8'h02, 8'h01, 8'h20, 8'h03, 7);
    run_op("and", 8'h07, 8'h05, 8'h24, 8'h05, 7);
    repeat (100) @(posedge clk);
    #1;
    check_val("hold_data", 32'(bus.tx_data), 32'h05);
    check_val("hold_start", 32'(bus.tx_start), 32'd0);

    run_op("sub", 8'h01, 8'h02, 8'h22, 8'hFF, 7);
    run_op("add_wrap", 8'hFF, 8'h01, 8'h20, 8'h00, 7);
    run_op("sra", 8'h80, 8'h01, 8'h03, 8'hC0, 7);
    run_op("srl", 8'h80, 8'h01, 8'h02, 8'h40, 7);
    run_op("sra_big", 8'h80, 8'h09, 8'h03, 8'hFF, 7);
    run_op("srl_big", 8'h80, 8'h08, 8'h02, 8'h00, 7);
    run_op("undef", 8'h12, 8'h34, 8'h3F, 8'h00, 7);
    run_op("nor", 8'h0F, 8'hF0, 8'h27, 8'h00, 7);
    run_op("or", 8'h0A, 8'h05, 8'h25, 8'h0F, 7);
    run_op("xor_b2b", 8'h0A, 8'h03, 8'h26, 8'h09, 0);
    run_op("op_hibits", 8'h03, 8'h04, 8'hE0, 8'h07, 0);

    // Partial sequence discarded by an asynchronous reset.
    send_byte(8'h05, 7);
    send_byte(8'h06, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("midrst_data", 32'(bus.tx_data), 32'h00);
    check_val("midrst_start", 32'(bus.tx_start), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    run_op("post_rst", 8'h01, 8'h01, 8'h20, 8'h02, 7);

    check_val("no_double_pulse", 32'(dbl_cnt), 32'd0);
    check_val("total_pulses", 32'(pulse_cnt), 32'd14);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_uart_alu_uart
